// File: rtl/sigma_np.sv
// Frame accumulator: sums 2^LOG2N strobed samples and emits the sum and floor average.
// Results and syn_out appear one clk after the Nth strobe edge; there is no backpressure.
module sigma_np #(
  parameter int DW    = 8,
  parameter int LOG2N = 4,
  parameter bit SM_IN = 1'b1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  clr,
  input  logic [DW-1:0]         data_in,
  input  logic                  syn_in,
  output logic [DW+LOG2N-1:0]   data_out,
  output logic [DW-1:0]         data_avg,
  output logic                  syn_out,
  output logic [LOG2N-1:0]      cnt
);
  localparam int AW = DW + LOG2N;

  logic          syn_d;
  logic          pulse;
  logic          last;
  logic [DW-1:0] d;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  assign pulse = syn_in & ~syn_d;
  assign last  = (cnt == {LOG2N{1'b1}});

  // Negating a zero magnitude yields zero, so sign-magnitude -0 needs no special case
  generate
    if (SM_IN) begin : g_sm
      logic [DW-1:0] mag;
      assign mag = {1'b0, data_in[DW-2:0]};
      assign d   = data_in[DW-1] ? -mag : mag;
    end else begin : g_tc
      assign d = data_in;
    end
  endgenerate

  assign sum = acc + {{LOG2N{d[DW-1]}}, d};

  always_ff @(posedge clk) begin
    if (res) begin
      syn_d    <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      data_out <= '0;
      data_avg <= '0;
      syn_out  <= 1'b0;
    end else begin
      syn_d   <= syn_in;
      syn_out <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (pulse) begin
        if (last) begin
          data_out <= sum;
          data_avg <= sum[AW-1:LOG2N];
          syn_out  <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + LOG2N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_np.sv
// Randomised and directed checks of sigma_np against a frame-level arithmetic model.
// Two instances: sign-magnitude 8b/N=16 and two's complement 12b/N=8.
module tb_sigma_np;
  localparam int N1 = 16;
  localparam int N2 = 8;

  logic        clk = 1'b0;
  logic        res, clr;
  logic [7:0]  d1;
  logic        s1;
  logic [11:0] o1;
  logic [7:0]  a1;
  logic        so1;
  logic [3:0]  c1;
  logic [11:0] d2;
  logic        s2;
  logic [14:0] o2;
  logic [11:0] a2;
  logic        so2;
  logic [2:0]  c2;

  int checks = 0;
  int errors = 0;

  int m1_sum, m1_cnt, m1_out, m1_avg, m1_syn;
  int m2_sum, m2_cnt, m2_out, m2_avg, m2_syn;

  always #5 clk = ~clk;

  sigma_np #(.DW(8), .LOG2N(4), .SM_IN(1'b1)) dut1 (
    .clk(clk), .res(res), .clr(clr), .data_in(d1), .syn_in(s1),
    .data_out(o1), .data_avg(a1), .syn_out(so1), .cnt(c1)
  );

  sigma_np #(.DW(12), .LOG2N(3), .SM_IN(1'b0)) dut2 (
    .clk(clk), .res(res), .clr(clr), .data_in(d2), .syn_in(s2),
    .data_out(o2), .data_avg(a2), .syn_out(so2), .cnt(c2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int fdiv(input int a, input int n);
    if (a >= 0) return a / n;
    return -((-a + n - 1) / n);
  endfunction

  function automatic int sm_val(input logic [7:0] d);
    int mag;
    mag = int'(d & 8'h7F);
    return d[7] ? -mag : mag;
  endfunction

  task automatic models_reset();
    m1_sum = 0; m1_cnt = 0; m1_out = 0; m1_avg = 0; m1_syn = 0;
    m2_sum = 0; m2_cnt = 0; m2_out = 0; m2_avg = 0; m2_syn = 0;
  endtask

  task automatic models_clr();
    m1_sum = 0; m1_cnt = 0; m1_syn = 0;
    m2_sum = 0; m2_cnt = 0; m2_syn = 0;
  endtask

  task automatic model1(input logic [7:0] d);
    int v;
    v = sm_val(d);
    if (m1_cnt == N1 - 1) begin
      m1_out = m1_sum + v;
      m1_avg = fdiv(m1_out, N1);
      m1_syn = 1;
      m1_sum = 0;
      m1_cnt = 0;
    end else begin
      m1_sum += v;
      m1_cnt++;
      m1_syn = 0;
    end
  endtask

  task automatic model2(input logic [11:0] d);
    int v;
    v = int'($signed(d));
    if (m2_cnt == N2 - 1) begin
      m2_out = m2_sum + v;
      m2_avg = fdiv(m2_out, N2);
      m2_syn = 1;
      m2_sum = 0;
      m2_cnt = 0;
    end else begin
      m2_sum += v;
      m2_cnt++;
      m2_syn = 0;
    end
  endtask

  task automatic check1();
    chk("cnt1", int'(c1), m1_cnt);
    chk("syn1", int'(so1), m1_syn);
    chk("out1", int'($signed(o1)), m1_out);
    chk("avg1", int'($signed(a1)), m1_avg);
  endtask

  task automatic check2();
    chk("cnt2", int'(c2), m2_cnt);
    chk("syn2", int'(so2), m2_syn);
    chk("out2", int'($signed(o2)), m2_out);
    chk("avg2", int'($signed(a2)), m2_avg);
  endtask

  // One strobe: high for one cycle, then low for gap cycles
  task automatic send1(input logic [7:0] d, input int gap);
    d1 = d; s1 = 1'b1;
    step();
    model1(d);
    check1();
    s1 = 1'b0;
    step();
    chk("syn1_width", int'(so1), 0);
    repeat (gap - 1) step();
  endtask

  task automatic send2(input logic [11:0] d, input int gap);
    d2 = d; s2 = 1'b1;
    step();
    model2(d);
    check2();
    s2 = 1'b0;
    step();
    chk("syn2_width", int'(so2), 0);
    repeat (gap - 1) step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    models_clr();
    chk("clr_cnt1", int'(c1), 0);
    chk("clr_hold1", int'($signed(o1)), m1_out);
  endtask

  initial begin
    res = 1'b1; clr = 1'b0;
    d1 = '0; s1 = 1'b0; d2 = '0; s2 = 1'b0;
    models_reset();
    repeat (3) step();
    check1();
    check2();
    res = 1'b0;
    step();

    // Constant +1 at a slow strobe rate
    for (int i = 0; i < N1; i++) send1(8'h01, 19);
    chk("t1_out", int'(o1), 12'h010);
    chk("t1_avg", int'(a1), 8'h01);

    for (int i = 0; i < N1; i++) send1(8'h85, 1);
    chk("t2_out_m5", int'(o1), 12'hFB0);
    chk("t2_avg_m5", int'(a1), 8'hFB);
    for (int i = 0; i < N1; i++) send1(8'hFF, 1);
    chk("t2_out_min", int'(o1), 12'h810);
    for (int i = 0; i < N1; i++) send1(8'h7F, 2);
    chk("t2_out_max", int'(o1), 12'h7F0);

    for (int i = 0; i < N1; i++) send1(8'h80, 1);
    chk("t3_negzero", int'(o1), 0);
    for (int i = 0; i < N1 - 1; i++) send1(8'h00, 1);
    send1(8'h81, 1);
    chk("t3_out_m1", int'(o1), 12'hFFF);
    chk("t3_avg_floor", int'(a1), 8'hFF);

    // Partial frame aborted by clr with a coincident strobe that must be dropped
    for (int i = 0; i < 5; i++) send1(8'h10, 1);
    d1 = 8'h10; s1 = 1'b1;
    do_clr();
    step();
    chk("t4_no_retrigger", int'(c1), 0);
    s1 = 1'b0;
    step();
    for (int i = 0; i < N1; i++) send1(8'h02, 1);
    chk("t4_out", int'(o1), 12'h020);

    // Strobe held high counts once
    d1 = 8'h03; s1 = 1'b1;
    step();
    model1(8'h03);
    check1();
    repeat (299) step();
    chk("t5_held_cnt", int'(c1), m1_cnt);
    s1 = 1'b0;
    step();
    for (int i = 0; i < 6; i++) send1(8'h04, 1);
    chk("t5_cnt7", int'(c1), 7);

    // Reset mid-frame with the strobe high across release
    d1 = 8'h05; s1 = 1'b1; res = 1'b1;
    step();
    models_reset();
    check1();
    check2();
    res = 1'b0;
    step();
    model1(8'h05);
    check1();
    s1 = 1'b0;
    step();
    for (int i = 0; i < N1 - 1; i++) send1(8'h01, 1);
    chk("t5_fresh_out", int'(o1), 20);

    for (int i = 0; i < N2 / 2; i++) begin
      send2(12'h800, 1);
      send2(12'h7FF, 1);
    end
    chk("t6_out", int'(o2), 15'h7FFC);
    chk("t6_avg", int'(a2), 12'hFFF);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N1; i++) begin
        if ($urandom_range(0, 40) == 0) do_clr();
        send1(8'($urandom), int'($urandom_range(1, 3)));
      end
    end
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N2; i++) send2(12'($urandom), int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
